// File: rtl/ustc_spmm_engine.sv
// rtl/ustc_spmm_engine.sv - sparse(A) x dense(B) matrix engine with accumulate and row drain
//
// Purpose: C[M][N] (+)= A_sparse * B[K][N]. A arrives as up to MAX_NNZ {row,col,val}
//   entries. N_UNIT MAC lanes consume N_UNIT entries against one B column per cycle.
//   Accumulators persist across passes when acc_keep is set, so K can be split.
//   Results are drained one C row per beat on a valid/ready stream.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start, acc_keep    begin a pass (IDLE only); keep (1) or clear (0) accumulators
//   in_a, in_nnz       packed entries [val|col|row] from LSB; number of valid entries
//   in_b               B[k][n] at (k*N+n)*DW_DATA
//   busy, done, err    pass in flight; end-of-pass pulse; out-of-range entry dropped
//   out_valid/ready    C row stream handshake
//   out_row, out_data  row index and packed row C[out_row][n] at n*DW_ACC
//   out_last           marks row M-1
module ustc_spmm_engine #(
    parameter int M       = 16,
    parameter int N       = 16,
    parameter int K       = 16,
    parameter int N_UNIT  = 4,
    parameter int MAX_NNZ = 64,
    parameter int DW_DATA = 8,
    parameter int DW_ROW  = 4,
    parameter int DW_COL  = 4,
    parameter int DW_ACC  = 24,
    parameter int DW_NNZ  = 7
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          start,
    input  logic                                          acc_keep,
    input  logic [MAX_NNZ*(DW_DATA+DW_COL+DW_ROW)-1:0]    in_a,
    input  logic [DW_NNZ-1:0]                             in_nnz,
    input  logic [K*N*DW_DATA-1:0]                        in_b,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          err,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [DW_ROW-1:0]                             out_row,
    output logic [N*DW_ACC-1:0]                           out_data,
    output logic                                          out_last
);

    localparam int DW_A  = DW_DATA + DW_COL + DW_ROW;
    localparam int G_MAX = MAX_NNZ / N_UNIT;
    localparam int DW_G  = (G_MAX > 1) ? $clog2(G_MAX) : 1;
    localparam int DW_PN = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DRAIN
    } state_t;

    state_t                       state_q;
    logic [MAX_NNZ*DW_A-1:0]      a_q;
    logic [K*N*DW_DATA-1:0]       b_q;
    logic [DW_NNZ-1:0]            nnz_q;
    logic [DW_G-1:0]              ptr_g_q;
    logic [DW_PN-1:0]             ptr_n_q;
    logic signed [DW_ACC-1:0]     acc_q [M][N];
    logic signed [DW_ACC-1:0]     acc_d [M][N];
    logic                         busy_q, done_q, err_q, out_valid_q, out_last_q;
    logic [DW_ROW-1:0]            out_row_q;
    logic [N*DW_ACC-1:0]          out_data_q;

    logic [DW_NNZ-1:0]            nnz_clamp;
    logic                         last_group;
    logic                         err_hit;
    logic [N_UNIT-1:0]            lane_act;
    logic [N_UNIT-1:0]            lane_ok;
    logic [DW_ROW-1:0]            lane_row [N_UNIT];
    logic signed [DW_ACC-1:0]     lane_add [N_UNIT];
    logic [DW_ROW-1:0]            drain_idx;
    logic [N*DW_ACC-1:0]          drain_data;

    assign nnz_clamp  = (32'(in_nnz) > MAX_NNZ) ? DW_NNZ'(MAX_NNZ) : in_nnz;
    // Last group once the first entry of the following group would be past nnz.
    assign last_group = ((32'(ptr_g_q) + 32'd1) * N_UNIT) >= 32'(nnz_q);

    for (genvar u = 0; u < N_UNIT; u++) begin : g_lane
        logic [31:0]               e;
        logic [DW_A-1:0]           ent;
        logic [DW_COL-1:0]         col;
        logic signed [DW_DATA-1:0] val;
        logic signed [DW_DATA-1:0] bval;
        logic signed [2*DW_DATA-1:0] prod;
        logic [31:0]               bidx;

        assign e    = 32'(ptr_g_q) * N_UNIT + u;
        assign ent  = a_q[e*DW_A +: DW_A];
        assign col  = ent[DW_ROW +: DW_COL];
        assign val  = ent[DW_ROW+DW_COL +: DW_DATA];
        assign bidx = (32'(col) * N + 32'(ptr_n_q)) * DW_DATA;
        // Out-of-range col reads garbage here but the lane is masked by lane_ok.
        assign bval = b_q[bidx +: DW_DATA];
        assign prod = val * bval;

        assign lane_row[u] = ent[DW_ROW-1:0];
        assign lane_add[u] = DW_ACC'(prod);
        assign lane_act[u] = e < 32'(nnz_q);
        assign lane_ok[u]  = lane_act[u] && (32'(lane_row[u]) < M) && (32'(col) < K);
    end

    assign err_hit = |(lane_act & ~lane_ok);

    // Lanes are chained so several lanes targeting one row all land in the same cycle.
    always_comb begin
        acc_d = acc_q;
        for (int u = 0; u < N_UNIT; u++) begin
            if (lane_ok[u]) begin
                acc_d[lane_row[u]][ptr_n_q] = acc_d[lane_row[u]][ptr_n_q] + lane_add[u];
            end
        end
    end

    // Row presented on the next drain step: row 0 when entering, else the following row.
    assign drain_idx = (out_valid_q && out_row_q != DW_ROW'(M-1)) ? out_row_q + DW_ROW'(1) : '0;

    always_comb begin
        drain_data = '0;
        for (int n = 0; n < N; n++) begin
            drain_data[n*DW_ACC +: DW_ACC] = acc_q[drain_idx][n];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            nnz_q       <= '0;
            ptr_g_q     <= '0;
            ptr_n_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_row_q   <= '0;
            out_data_q  <= '0;
            for (int r = 0; r < M; r++) begin
                for (int n = 0; n < N; n++) begin
                    acc_q[r][n] <= '0;
                end
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        nnz_q   <= nnz_clamp;
                        err_q   <= 1'b0;
                        ptr_g_q <= '0;
                        ptr_n_q <= '0;
                        busy_q  <= 1'b1;
                        if (!acc_keep) begin
                            for (int r = 0; r < M; r++) begin
                                for (int n = 0; n < N; n++) begin
                                    acc_q[r][n] <= '0;
                                end
                            end
                        end
                        state_q <= (nnz_clamp == '0) ? S_DRAIN : S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    acc_q <= acc_d;
                    if (err_hit) begin
                        err_q <= 1'b1;
                    end
                    if (ptr_n_q == DW_PN'(N-1)) begin
                        ptr_n_q <= '0;
                        if (last_group) begin
                            state_q <= S_DRAIN;
                        end else begin
                            ptr_g_q <= ptr_g_q + DW_G'(1);
                        end
                    end else begin
                        ptr_n_q <= ptr_n_q + DW_PN'(1);
                    end
                end
                S_DRAIN: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_row_q   <= '0;
                        out_data_q  <= drain_data;
                        out_last_q  <= (M == 1);
                    end else if (out_ready) begin
                        if (out_row_q == DW_ROW'(M-1)) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            out_row_q  <= drain_idx;
                            out_data_q <= drain_data;
                            out_last_q <= (drain_idx == DW_ROW'(M-1));
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_ustc_spmm_engine.sv
// tb/tb_ustc_spmm_engine.sv - scoreboard bench for ustc_spmm_engine
module tb_ustc_spmm_engine;

    localparam int M = 16, N = 16, K = 16, NU = 4, MAXN = 64;
    localparam int DWD = 8, DWA = 16, DWACC = 24, DWNNZ = 7;
    // second instance: small M/K to reach out-of-range indices, narrow accumulator for wrap
    localparam int M2 = 8, K2 = 8, MAXN2 = 8, DWACC2 = 16, DWNNZ2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    reset, start, acc_keep, out_ready;
    logic [MAXN*DWA-1:0]     in_a;
    logic [DWNNZ-1:0]        in_nnz;
    logic [K*N*DWD-1:0]      in_b;
    logic                    busy, done, err, out_valid, out_last;
    logic [3:0]              out_row;
    logic [N*DWACC-1:0]      out_data;

    logic                    start2, keep2, out_ready2;
    logic [MAXN2*DWA-1:0]    in_a2;
    logic [DWNNZ2-1:0]       in_nnz2;
    logic [K2*N*DWD-1:0]     in_b2;
    logic                    busy2, done2, err2, out_valid2, out_last2;
    logic [3:0]              out_row2;
    logic [N*DWACC2-1:0]     out_data2;

    ustc_spmm_engine dut (
        .clk(clk), .reset(reset), .start(start), .acc_keep(acc_keep),
        .in_a(in_a), .in_nnz(in_nnz), .in_b(in_b),
        .busy(busy), .done(done), .err(err),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_row(out_row), .out_data(out_data), .out_last(out_last)
    );

    ustc_spmm_engine #(.M(M2), .K(K2), .MAX_NNZ(MAXN2), .DW_ACC(DWACC2), .DW_NNZ(DWNNZ2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .acc_keep(keep2),
        .in_a(in_a2), .in_nnz(in_nnz2), .in_b(in_b2),
        .busy(busy2), .done(done2), .err(err2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_row(out_row2), .out_data(out_data2), .out_last(out_last2)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]         row;
        logic [N*DWACC-1:0] data;
        logic               last;
    } beat_t;
    typedef struct {
        logic [3:0]          row;
        logic [N*DWACC2-1:0] data;
        logic                last;
    } beat2_t;

    beat_t  q1[$];
    beat2_t q2[$];
    beat_t  mb;
    beat2_t mb2;

    logic signed [DWACC-1:0] exp_c [M][N];

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    // scoreboard monitors: compare every accepted beat against the queued expectation
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected: got row %0d with empty scoreboard", out_row);
            end else begin
                mb = q1.pop_front();
                if (out_row !== mb.row || out_data !== mb.data || out_last !== mb.last) begin
                    bad++;
                    $display("FAIL beat: got row=%0d last=%0b data=%h required row=%0d last=%0b data=%h",
                             out_row, out_last, out_data, mb.row, mb.last, mb.data);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && out_valid2 && out_ready2) begin
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL beat2_unexpected: got row %0d with empty scoreboard", out_row2);
            end else begin
                mb2 = q2.pop_front();
                if (out_row2 !== mb2.row || out_data2 !== mb2.data || out_last2 !== mb2.last) begin
                    bad++;
                    $display("FAIL beat2: got row=%0d last=%0b data=%h required row=%0d last=%0b data=%h",
                             out_row2, out_last2, out_data2, mb2.row, mb2.last, mb2.data);
                end
            end
        end
    end

    task automatic set_e(input int e, input int r, input int c, input int v);
        in_a[e*DWA +: DWA] = {8'(v), 4'(c), 4'(r)};
    endtask

    task automatic set_b(input int k, input int n, input int v);
        in_b[(k*N+n)*DWD +: DWD] = 8'(v);
    endtask

    task automatic clear_all();
        in_a = '0;
        in_b = '0;
        for (int r = 0; r < M; r++)
            for (int n = 0; n < N; n++)
                exp_c[r][n] = '0;
    endtask

    task automatic push_exp();
        beat_t b;
        for (int r = 0; r < M; r++) begin
            b.row  = 4'(r);
            b.last = (r == M-1);
            for (int n = 0; n < N; n++)
                b.data[n*DWACC +: DWACC] = exp_c[r][n];
            q1.push_back(b);
        end
    endtask

    // issue one pass, optionally disturb it (input change + stray start) or stall the drain
    task automatic run_pass(input string nm, input logic keep, input int nnz, input int exp_lat,
                            input bit bp, input bit disturb);
        int lat;
        int cnt;
        logic [3:0]         sv_row;
        logic [N*DWACC-1:0] sv_data;
        @(posedge clk); #1;
        start = 1'b1; acc_keep = keep; in_nnz = DWNNZ'(nnz);
        @(posedge clk); #1;
        start = 1'b0;
        chk({nm, "_busy"}, busy, 1);
        lat = 0;
        if (disturb) begin
            in_a = '1; in_b = '1; acc_keep = 1'b0; in_nnz = '0;
            repeat (5) begin @(posedge clk); #1; lat++; end
            start = 1'b1;
            @(posedge clk); #1; lat++;
            start = 1'b0;
        end
        while (!out_valid && lat < 2000) begin
            @(posedge clk); #1; lat++;
        end
        chk({nm, "_latency"}, lat, exp_lat);
        if (bp) begin
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b0;
            sv_row  = out_row;
            sv_data = out_data;
            repeat (5) begin
                @(posedge clk); #1;
                chk({nm, "_bp_row_stable"}, out_row, sv_row);
                chk({nm, "_bp_data_stable"}, out_data == sv_data, 1);
                chk({nm, "_bp_valid_held"}, out_valid, 1);
            end
            out_ready = 1'b1;
        end
        cnt = 0;
        while (!done && cnt < 1000) begin
            @(posedge clk); #1; cnt++;
        end
        chk({nm, "_done_seen"}, done, 1);
        chk({nm, "_busy_at_done"}, busy, 0);
        chk({nm, "_valid_at_done"}, out_valid, 0);
        chk({nm, "_beats_left"}, q1.size(), 0);
        @(posedge clk); #1;
        chk({nm, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int cnt;
        beat2_t b2;
        reset = 1'b1; start = 1'b0; acc_keep = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_nnz = '0;
        start2 = 1'b0; keep2 = 1'b0; out_ready2 = 1'b1; in_a2 = '0; in_b2 = '0; in_nnz2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_row", out_row, 0);
        chk("rst_data_zero", out_data == '0, 1);
        reset = 1'b0;

        // identity with backpressure mid-drain
        clear_all();
        for (int i = 0; i < 16; i++) set_e(i, i, i, 1);
        for (int k = 0; k < K; k++) for (int n = 0; n < N; n++) set_b(k, n, k + n);
        for (int r = 0; r < M; r++) for (int n = 0; n < N; n++) exp_c[r][n] = DWACC'(r + n);
        push_exp();
        run_pass("ident", 1'b0, 16, 65, 1'b1, 1'b0);
        chk("ident_err", err, 0);

        // four lanes hitting row 3 in one cycle
        clear_all();
        for (int i = 0; i < 4; i++) set_e(i, 3, i, 2);
        for (int k = 0; k < K; k++) for (int n = 0; n < N; n++) set_b(k, n, 1);
        for (int n = 0; n < N; n++) exp_c[3][n] = 8;
        push_exp();
        run_pass("collide", 1'b0, 4, 17, 1'b0, 1'b0);

        // K-split across passes
        clear_all();
        set_e(0, 0, 0, 5);
        for (int n = 0; n < N; n++) begin set_b(0, n, 3); exp_c[0][n] = 15; end
        push_exp();
        run_pass("ksplit1", 1'b0, 1, 17, 1'b0, 1'b0);
        clear_all();
        set_e(0, 0, 1, -2);
        for (int n = 0; n < N; n++) begin set_b(1, n, 4); exp_c[0][n] = 7; end
        push_exp();
        run_pass("ksplit2", 1'b1, 1, 17, 1'b0, 1'b0);
        clear_all();
        push_exp();
        run_pass("ksplit3", 1'b0, 0, 1, 1'b0, 1'b0);

        // largest legal row and col
        clear_all();
        set_e(0, 15, 15, 3);
        for (int n = 0; n < N; n++) begin set_b(15, n, n); exp_c[15][n] = DWACC'(3 * n); end
        push_exp();
        run_pass("edge15", 1'b0, 1, 17, 1'b0, 1'b0);
        chk("edge15_err", err, 0);

        // in_nnz above MAX_NNZ clamps to 64 entries
        clear_all();
        for (int i = 0; i < MAXN; i++) set_e(i, 0, 0, 1);
        for (int n = 0; n < N; n++) begin set_b(0, n, 1); exp_c[0][n] = 64; end
        push_exp();
        run_pass("clamp", 1'b0, 100, 257, 1'b0, 1'b0);

        // inputs changed and start pulsed while busy: registered pass unaffected
        clear_all();
        for (int i = 0; i < 16; i++) set_e(i, i, i, 1);
        for (int k = 0; k < K; k++) for (int n = 0; n < N; n++) set_b(k, n, k + n);
        for (int r = 0; r < M; r++) for (int n = 0; n < N; n++) exp_c[r][n] = DWACC'(r + n);
        push_exp();
        run_pass("busy_start", 1'b0, 16, 65, 1'b0, 1'b1);

        // reset mid-COMPUTE aborts and clears accumulators
        clear_all();
        for (int i = 0; i < 16; i++) set_e(i, i, i, 1);
        for (int k = 0; k < K; k++) for (int n = 0; n < N; n++) set_b(k, n, 1);
        @(posedge clk); #1;
        start = 1'b1; acc_keep = 1'b1; in_nnz = 7'd16;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_valid", out_valid, 0);
        reset = 1'b0;
        clear_all();
        push_exp();
        run_pass("after_abort", 1'b1, 0, 1, 1'b0, 1'b0);

        // second instance: dropped entries and accumulator wrap
        for (int i = 0; i < 3; i++) in_a2[i*DWA +: DWA] = {8'd127, 4'd0, 4'd1};
        in_a2[3*DWA +: DWA] = {8'd5, 4'd0, 4'd9};
        in_a2[4*DWA +: DWA] = {8'd1, 4'd9, 4'd2};
        for (int n = 0; n < N; n++) in_b2[n*DWD +: DWD] = 8'd127;
        for (int r = 0; r < M2; r++) begin
            b2.row  = 4'(r);
            b2.last = (r == M2-1);
            for (int n = 0; n < N; n++)
                b2.data[n*DWACC2 +: DWACC2] = (r == 1) ? -16'sd17149 : 16'sd0;
            q2.push_back(b2);
        end
        @(posedge clk); #1;
        start2 = 1'b1; in_nnz2 = 4'd5;
        @(posedge clk); #1;
        start2 = 1'b0;
        cnt = 0;
        while (!out_valid2 && cnt < 1000) begin @(posedge clk); #1; cnt++; end
        chk("wrap_latency", cnt, 33);
        chk("range_err", err2, 1);
        cnt = 0;
        while (!done2 && cnt < 1000) begin @(posedge clk); #1; cnt++; end
        chk("wrap_done", done2, 1);
        chk("wrap_err_held", err2, 1);
        chk("wrap_beats_left", q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
